fpu_addsub: RTL
===============

FPU_ADDSUB -- requirements
Module: fpu_addsub

Interface
REQ-001 Parameter EXP_W, default 6, exponent field width in bits.
REQ-002 Parameter MAN_W, default 25, stored mantissa field width in bits; word width W = 1+EXP_W+MAN_W.
REQ-003 clock100KHz  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; operands and mode sampled when start=1 and busy=0.
REQ-006 op_sub  input  1  0 = A+B, 1 = A-B (B sign inverted at sample).
REQ-007 op_A_in  input  W  operand A {sign, exp, mantissa}.
REQ-008 op_B_in  input  W  operand B, same format.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse, coincident with new data_out/status_out.
REQ-011 data_out  output  W  result, held until the next done.
REQ-012 status_out  output  4  one-hot {UNDERFLOW, OVERFLOW, INEXACT, EXACT}, held with data_out.

Function
REQ-013 Value is 1.mantissa x 2^exp (unbiased unsigned exponent); a word with exp=0 and mantissa=0 is zero (hidden bit 0), either sign.
REQ-014 FSM states IDLE, ALIGN, OPERATE, NORMALIZE, ROUND, OUTPUT; order IDLE->ALIGN->OPERATE->NORMALIZE->ROUND->OUTPUT->IDLE.
REQ-015 ALIGN: smaller-exponent mantissa right-shifted by the exponent difference; guard bit and OR-of-shifted-out sticky bit retained; result exponent = larger exponent.
REQ-016 OPERATE: equal effective signs add magnitudes; otherwise larger magnitude minus smaller, result sign from larger; exact zero difference gives +0.
REQ-017 NORMALIZE: one shift per cycle; carry-out -> right shift, exponent+1; hidden bit 0 and non-zero -> left shift, exponent-1; at least one cycle, exits when normalised or zero.
REQ-018 Latency from accepted start to done = 5 + number of normalisation shifts (minimum 5 clocks).
REQ-019 start while busy=1 is ignored; no queueing.
REQ-020 Exponent exceeding 2^EXP_W-1 (in NORMALIZE or after rounding carry) -> data_out = {sign, all-ones exp, all-ones mantissa}, OVERFLOW.
REQ-021 Exponent required below 0 with non-zero mantissa -> data_out = {sign, zeros}, UNDERFLOW.
REQ-022 Otherwise INEXACT if guard or sticky set, else EXACT; exactly one status bit set.
REQ-023 Rounding carry into bit MAN_W+1 renormalises within ROUND (shift right, exponent+1).

Reset
REQ-024 reset=1 at a clock edge forces state IDLE, busy=0, done=0, data_out=0, status_out=4'b0001, discarding any operation in progress.

Configuration
REQ-025 Macro FPU_ROUND_NEAREST_EN defined: round-to-nearest-even using guard/sticky.
REQ-026 Macro undefined: truncation (ROUND never increments); INEXACT flagging unchanged.

Structure
REQ-027 Package fpu_pkg holds state_t, status bit-index constants and the EXACT/INEXACT/OVERFLOW/UNDERFLOW one-hot constants.
REQ-028 Sub-module fpu_align_shift: combinational right shifter producing shifted mantissa, guard and sticky.

Verification (EXP_W=6, MAN_W=25)
REQ-029 A=B=0x02000000, add -> done after 6 clocks, data_out=0x04000000, status 0001.
REQ-030 A=B=0x3A123456, op_sub=1 -> data_out=0x00000000, status 0001.
REQ-031 A=B=0x7E000000, add -> data_out=0x7FFFFFFF, status 0100.
REQ-032 A=0x04000000, B=0x02000001, add -> data_out=0x05000000, status 0010, with and without macro.
REQ-033 A=0x02000000, B=0x02000001, op_sub=1 -> data_out=0x80000000, status 1000.
REQ-034 reset pulsed during NORMALIZE of REQ-033 -> next cycle busy=0, done=0, data_out=0, status 0001; new start then completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the floating-point add/subtract unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state type, status bit positions and one-hot status codes.
package fpu_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ALIGN     = 3'd1,
      OPERATE   = 3'd2,
      NORMALIZE = 3'd3,
      ROUND     = 3'd4,
      OUTPUT    = 3'd5
   } state_t;

   // Bit positions inside status_out
   localparam int STAT_EXACT_BIT     = 0;
   localparam int STAT_INEXACT_BIT   = 1;
   localparam int STAT_OVERFLOW_BIT  = 2;
   localparam int STAT_UNDERFLOW_BIT = 3;

   // One-hot status codes
   localparam logic [3:0] STAT_EXACT     = 4'b0001;
   localparam logic [3:0] STAT_INEXACT   = 4'b0010;
   localparam logic [3:0] STAT_OVERFLOW  = 4'b0100;
   localparam logic [3:0] STAT_UNDERFLOW = 4'b1000;

endpackage

// File: rtl/fpu_align_shift.sv
// Alignment shifter: right-shifts a significand, keeping guard and sticky.
// Latency: combinational.
// Backpressure: none.
// Ports: sig_in (significand incl. hidden bit), shamt (exponent difference)
//        -> sig_out (shifted significand), guard (last bit shifted out),
//        sticky (OR of every bit shifted out below the guard).
module fpu_align_shift #(
   parameter int EXP_W = 6,
   parameter int SIG_W = 26
) (
   input  logic [SIG_W-1:0] sig_in,
   input  logic [EXP_W-1:0] shamt,
   output logic [SIG_W-1:0] sig_out,
   output logic             guard,
   output logic             sticky
);

   always_comb begin
      sig_out = sig_in >> shamt;
      guard   = 1'b0;
      sticky  = 1'b0;
      // Bit i lands in the guard position when shamt == i+1 and is lost
      // below the guard when shamt > i+1; large shifts simply leave
      // everything in the sticky.
      for (int i = 0; i < SIG_W; i++) begin
         if (i + 1 == int'(shamt)) guard = sig_in[i];
         if (i + 1 <  int'(shamt)) sticky = sticky | sig_in[i];
      end
   end

endmodule

// File: rtl/fpu_addsub.sv
// Multi-cycle floating-point adder/subtractor (unbiased unsigned exponent).
// Latency: 5 clocks from accepted start to done, +1 per normalisation shift.
// Backpressure: start is ignored while busy; no queueing.
// Ports: clock100KHz, reset (sync, active-high), start, op_sub, op_A_in,
//        op_B_in -> busy, done (1-cycle pulse), data_out, status_out
//        (one-hot {UNDERFLOW, OVERFLOW, INEXACT, EXACT}).
// Build option: FPU_ROUND_NEAREST_EN selects round-to-nearest-even,
//        otherwise results are truncated.
module fpu_addsub #(
   parameter int EXP_W = 6,
   parameter int MAN_W = 25
) (
   input  logic                   clock100KHz,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   op_sub,
   input  logic [EXP_W+MAN_W:0]   op_A_in,
   input  logic [EXP_W+MAN_W:0]   op_B_in,
   output logic                   busy,
   output logic                   done,
   output logic [EXP_W+MAN_W:0]   data_out,
   output logic [3:0]             status_out
);

   import fpu_pkg::*;

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int N  = MAN_W + 1;          // significand incl. hidden bit
   localparam int SW = MAN_W + 4;          // {carry, hidden, mantissa, guard, sticky}
   localparam logic [EXP_W-1:0] EXP_MAX = '1;

   state_t state, state_nx;

   // Captured operands (B sign already adjusted for subtraction)
   logic             a_sgn, b_sgn;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_man, b_man;

   // Aligned operands
   logic             lg_sgn, sm_sgn;
   logic [N-1:0]     lg_sig, sm_sig;
   logic             sm_grd, sm_stk;

   // Working result
   logic [SW-1:0]    acc;
   logic [EXP_W-1:0] res_exp;
   logic             res_sgn;
   logic             ovf, unf;
   logic [W-1:0]     res_word;
   logic [3:0]       res_stat;

   // ------------------------------------------------------------------
   // Alignment: the operand with the larger {exp, man} is the reference;
   // comparing the packed field works because zero is the smallest code.
   // ------------------------------------------------------------------
   logic             a_big;
   logic [N-1:0]     a_sig, b_sig, al_in, al_sig;
   logic [EXP_W-1:0] al_shamt;
   logic             al_grd, al_stk;

   always_comb begin
      a_big    = ({a_exp, a_man} >= {b_exp, b_man});
      a_sig    = {(|{a_exp, a_man}), a_man};
      b_sig    = {(|{b_exp, b_man}), b_man};
      al_in    = a_big ? b_sig : a_sig;
      al_shamt = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
   end

   fpu_align_shift #(.EXP_W(EXP_W), .SIG_W(N)) u_align (
      .sig_in  (al_in),
      .shamt   (al_shamt),
      .sig_out (al_sig),
      .guard   (al_grd),
      .sticky  (al_stk)
   );

   // ------------------------------------------------------------------
   // Operate: the smaller operand is never larger than the reference, so
   // the difference cannot go negative.
   // ------------------------------------------------------------------
   logic          eff_sub;
   logic [SW-1:0] op_res;

   always_comb begin
      eff_sub = (lg_sgn != sm_sgn);
      if (eff_sub)
         op_res = {1'b0, lg_sig, 2'b00} - {1'b0, sm_sig, sm_grd, sm_stk};
      else
         op_res = {1'b0, lg_sig, 2'b00} + {1'b0, sm_sig, sm_grd, sm_stk};
   end

   // ------------------------------------------------------------------
   // Normalise decision: stay while another shift is legal.
   // ------------------------------------------------------------------
   logic need_rsh, need_lsh, norm_stay;

   always_comb begin
      need_rsh  = acc[SW-1];
      need_lsh  = !acc[SW-1] && !acc[SW-2] && (|acc);
      norm_stay = (need_rsh && (res_exp != EXP_MAX)) ||
                  (need_lsh && (res_exp != '0));
   end

   // ------------------------------------------------------------------
   // Rounding increment.
   // ------------------------------------------------------------------
   logic         rnd_inc;
   logic         rnd_cry, rnd_hid;
   logic [MAN_W-1:0] rnd_man;
   logic         inexact;

   always_comb begin
`ifdef FPU_ROUND_NEAREST_EN
      // Ties go to the even mantissa
      rnd_inc = acc[1] & (acc[0] | acc[2]);
`else
      rnd_inc = 1'b0;
`endif
      {rnd_cry, rnd_hid, rnd_man} = {1'b0, acc[SW-2:2]} + {{N{1'b0}}, rnd_inc};
      inexact = acc[1] | acc[0];
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clock100KHz) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (start) state_nx = ALIGN;
         ALIGN:     state_nx = OPERATE;
         OPERATE:   state_nx = NORMALIZE;
         NORMALIZE: if (!norm_stay) state_nx = ROUND;
         ROUND:     state_nx = OUTPUT;
         OUTPUT:    state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath and outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clock100KHz) begin
      if (reset) begin
         a_sgn      <= 1'b0;
         b_sgn      <= 1'b0;
         a_exp      <= '0;
         b_exp      <= '0;
         a_man      <= '0;
         b_man      <= '0;
         lg_sgn     <= 1'b0;
         sm_sgn     <= 1'b0;
         lg_sig     <= '0;
         sm_sig     <= '0;
         sm_grd     <= 1'b0;
         sm_stk     <= 1'b0;
         acc        <= '0;
         res_exp    <= '0;
         res_sgn    <= 1'b0;
         ovf        <= 1'b0;
         unf        <= 1'b0;
         res_word   <= '0;
         res_stat   <= STAT_EXACT;
         busy       <= 1'b0;
         done       <= 1'b0;
         data_out   <= '0;
         status_out <= STAT_EXACT;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sgn <= op_A_in[W-1];
                  a_exp <= op_A_in[W-2 -: EXP_W];
                  a_man <= op_A_in[MAN_W-1:0];
                  b_sgn <= op_B_in[W-1] ^ op_sub;
                  b_exp <= op_B_in[W-2 -: EXP_W];
                  b_man <= op_B_in[MAN_W-1:0];
                  ovf   <= 1'b0;
                  unf   <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            ALIGN: begin
               lg_sgn  <= a_big ? a_sgn : b_sgn;
               sm_sgn  <= a_big ? b_sgn : a_sgn;
               lg_sig  <= a_big ? a_sig : b_sig;
               res_exp <= a_big ? a_exp : b_exp;
               sm_sig  <= al_sig;
               sm_grd  <= al_grd;
               sm_stk  <= al_stk;
            end
            OPERATE: begin
               acc     <= op_res;
               // An exact cancellation is always +0
               res_sgn <= (eff_sub && (op_res == '0)) ? 1'b0 : lg_sgn;
            end
            NORMALIZE: begin
               if (need_rsh) begin
                  if (res_exp == EXP_MAX) begin
                     ovf <= 1'b1;
                  end else begin
                     acc     <= {1'b0, acc[SW-1:2], acc[1] | acc[0]};
                     res_exp <= res_exp + 1'b1;
                  end
               end else if (need_lsh) begin
                  if (res_exp == '0) begin
                     unf <= 1'b1;
                  end else begin
                     // Guard moves into the mantissa; sticky stays put
                     acc     <= {acc[SW-2:1], 1'b0, acc[0]};
                     res_exp <= res_exp - 1'b1;
                  end
               end
            end
            ROUND: begin
               if (ovf) begin
                  res_word <= {res_sgn, EXP_MAX, {MAN_W{1'b1}}};
                  res_stat <= STAT_OVERFLOW;
               end else if (unf) begin
                  res_word <= {res_sgn, {(W-1){1'b0}}};
                  res_stat <= STAT_UNDERFLOW;
               end else if (rnd_cry) begin
                  // Rounding rippled into a new integer bit: 1.000.. x 2^(e+1)
                  if (res_exp == EXP_MAX) begin
                     res_word <= {res_sgn, EXP_MAX, {MAN_W{1'b1}}};
                     res_stat <= STAT_OVERFLOW;
                  end else begin
                     res_word <= {res_sgn, res_exp + 1'b1, {MAN_W{1'b0}}};
                     res_stat <= inexact ? STAT_INEXACT : STAT_EXACT;
                  end
               end else if (!rnd_hid) begin
                  res_word <= {res_sgn, {(W-1){1'b0}}};
                  res_stat <= inexact ? STAT_INEXACT : STAT_EXACT;
               end else begin
                  res_word <= {res_sgn, res_exp, rnd_man};
                  res_stat <= inexact ? STAT_INEXACT : STAT_EXACT;
               end
            end
            OUTPUT: begin
               data_out   <= res_word;
               status_out <= res_stat;
               done       <= 1'b1;
               busy       <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
